temporizador_multi: RTL
=======================

# temporizador_multi

Multi-channel programmable timer. It generalises the single fixed-length one-shot timer to CH independent channels. Each channel has a run-time period, a one-shot or periodic mode, retrigger and stop. It sits between the game-logic FSMs and anything that needs timed events (animation ticks, hunger/sleep decay, button lockout), and gives each consumer a level `busy` and a single-cycle `done`.

## Interface
- `CH`, 4: number of independent channels.
- `W`, 26: counter/period width. 2^26 covers 1 s at 50 MHz (50_000_000).
- `clk`  in  1: system clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  CH: per-channel start/retrigger, sampled each edge.
- `stop`  in  CH: per-channel abort, sampled each edge.
- `periodic`  in  CH: mode, 0 = one-shot, 1 = periodic. Latched on start.
- `period`  in  CH*W: channel i period in clock cycles at bits [i*W +: W]. Latched on start.
- `busy`  out  CH: channel running.
- `done`  out  CH: one-cycle expiry pulse.
- `any_done`  out  1: registered OR of the `done` terms being set on this edge, so it is coincident with `done`.

## Operation
- Per-channel FSM, states IDLE and RUN. The CH channels are fully independent, with no shared state.
- Reset: every channel goes to IDLE, counter = 0, latched period/mode = 0. `busy`, `done` and `any_done` = 0. Asserting `rst_n` low mid-count aborts immediately, with no `done`.
- P_eff = latched period. `period` = 0 is treated as P_eff = 1.
- IDLE:
  - `start`=1 and `stop`=0: latch `period` and `periodic`, counter = P_eff, go to RUN, `busy`<=1.
  - Otherwise hold.
- RUN, evaluated at each edge in this priority order:
  1. `stop`=1: go to IDLE, `busy`<=0, no `done`. Stop beats start on the same edge.
  2. `start`=1 (retrigger): re-latch `period`/`periodic`, counter = new P_eff, stay in RUN, no `done`. This wins even on the edge where expiry would occur.
  3. Counter = 1 (expiry): `done`<=1.
     - One-shot: go to IDLE, `busy`<=0.
     - Periodic: counter = latched P_eff, `busy` stays 1.
  4. Otherwise counter decrements by 1.
- `done` is 0 on every edge not listed above; it is a pure one-cycle pulse.
- Changes to `period` or `periodic` while in RUN have no effect until the next start or retrigger.
- Counter is W bits, unsigned. It never wraps, because a reload always occurs at 1.

## Timing
- Start sampled at edge k, one-shot, period P:
  - `busy` = 1 from edge k to edge k+P, i.e. exactly P cycles.
  - `done` = 1 for the single cycle following edge k+P, coincident with `busy` falling.
- Periodic: `done` pulses after edges k+P, k+2P, k+3P, …, and `busy` stays high continuously until `stop`.
- Back-to-back one-shot: `start` sampled at edge k+P, the edge where `done` is set, is seen in RUN and is a retrigger, so no `done` is produced at k+P. `start` at edge k+P+1, seen in IDLE, restarts with 1 cycle of `busy` low.
- Start-to-busy latency: 1 edge. Stop-to-idle latency: 1 edge.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset/idle: hold `rst_n`=0, then release.
  - All outputs 0.
  - Pulse `rst_n` low at cycle 3 of a P=10 run: `busy` clears asynchronously, no `done`.
- One-shot: channel 0, P=5, `periodic`=0, start pulse at edge 0.
  - `busy` high after edges 0–4, low after edge 5.
  - `done` and `any_done` high exactly one cycle after edge 5.
- Periodic plus stop: channel 1, P=3, `periodic`=1.
  - `done` after edges 3, 6, 9.
  - `stop` at edge 10: `busy` low after edge 10, no `done` at 12.
- Retrigger and priority:
  - P=4, start at 0, start again at 3 with P=6: `done` after edge 9 only.
  - `stop` and `start` together in RUN: channel goes to IDLE.
  - Retrigger on the expiry edge suppresses that `done`.
- Edge values:
  - P=0: behaves as P=1, `done` after edge 1.
  - P=2^W−1 (use W=8 bench, P=255): `done` after edge 255, no wrap.
  - Changing `period` mid-run has no effect.
- Channel independence: all 4 channels running with P=2, 3, 5, 7 (periodic).
  - `done` pattern matches the per-channel schedule.
  - `any_done` equals the OR of the channel pulses.
  - Simultaneous expiries are handled.

Source files
------------

// File: rtl/temporizador_multi.sv
// Multi-channel programmable timer: CH independent one-shot/periodic channels,
// each with a level busy and a single-cycle done, plus a combined any_done.
module temporizador_multi #(
  parameter int CH = 4,
  parameter int W  = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] start,
  input  logic [CH-1:0] stop,
  input  logic [CH-1:0] periodic,
  input  logic [CH*W-1:0] period,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] done,
  output logic          any_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [W-1:0]  cnt_q   [CH];
  logic [W-1:0]  cnt_d   [CH];
  logic [W-1:0]  per_q   [CH];
  logic [W-1:0]  per_d   [CH];
  logic [CH-1:0] mode_q, mode_d;
  logic [CH-1:0] done_d;

  // A programmed period of zero runs as a one-cycle period.
  function automatic logic [W-1:0] p_eff(input logic [W-1:0] p);
    return (p == '0) ? ONE : p;
  endfunction

  // NOTE: every next-state signal gets its hold value first, so no path through
  // the case below can leave one unassigned and infer a latch.
  always_comb begin
    mode_d = mode_q;
    done_d = '0;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      per_d[i]   = per_q[i];
      case (state_q[i])
        IDLE: begin
          if (start[i] && !stop[i]) begin
            per_d[i]   = period[i*W +: W];
            mode_d[i]  = periodic[i];
            cnt_d[i]   = p_eff(period[i*W +: W]);
            state_d[i] = RUN;
          end
        end
        RUN: begin
          if (stop[i]) begin
            state_d[i] = IDLE;
          end else if (start[i]) begin
            // Retrigger wins over an expiry on the same edge.
            per_d[i]  = period[i*W +: W];
            mode_d[i] = periodic[i];
            cnt_d[i]  = p_eff(period[i*W +: W]);
          end else if (cnt_q[i] == ONE) begin
            done_d[i] = 1'b1;
            if (mode_q[i]) cnt_d[i] = p_eff(per_q[i]);
            else           state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - ONE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        per_q[i]   <= '0;
      end
      mode_q   <= '0;
      done     <= '0;
      any_done <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        per_q[i]   <= per_d[i];
      end
      mode_q   <= mode_d;
      done     <= done_d;
      any_done <= |done_d;
    end
  end

  // busy decodes only the state flops, so it stays a registered output.
  always_comb begin
    busy = '0;
    for (int i = 0; i < CH; i++) busy[i] = (state_q[i] == RUN);
  end

endmodule
